// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared types and defaults for the common-data-bus stage
//
// Purpose: default widths, the "no producer" tag value, the source
// enumeration used by the round-robin arbiter and the queued entry type.
// Optional feature macro used by cdb_arbiter: CDB_STATS_EN.

package cdb_pkg;

  localparam int CDB_DATA_W = 16;
  localparam int CDB_TAG_W  = 3;
  localparam int CDB_DEPTH  = 4;

  // Tag value reserved for "no producer"; never broadcast.
  localparam int TAG_NONE = 0;

  typedef enum logic {
    SRC_ADD = 1'b0,
    SRC_MUL = 1'b1
  } cdb_src_e;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - per-source circular result queue
//
// Purpose: holds completed {tag, data} results of one functional unit until
// the arbiter broadcasts them. Read/write pointers wrap modulo DEPTH, which
// must be a power of two (min 2).
//
// Ports:
//   clock1     in   clock, rising edge
//   reset      in   synchronous active-high reset, empties the queue
//   push       in   enqueue push_entry (ignored while full)
//   push_entry in   entry to enqueue
//   pop        in   drop the head entry (ignored while empty)
//   head       out  current head entry (valid while !empty)
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  number of stored entries, clog2(DEPTH)+1 bits

module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int  DEPTH   = CDB_DEPTH,
  parameter type entry_t = cdb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clock1,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset: an entry is only ever read after being written.
  always_ff @(posedge clock1) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clock1) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: natural pointer overflow is the modulo wrap.
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - Tomasulo common-data-bus arbiter and broadcaster
//
// Purpose: queues adder and multiplier results per source and broadcasts at
// most one {tag, data} per cycle, round-robin between sources, back to the
// register table and waiting reservation stations.
// Optional feature macro: CDB_STATS_EN (adds saturating broadcast/hold counters).
//
// Ports:
//   clock1          in   clock, rising edge
//   reset           in   synchronous active-high reset
//   add_valid/tag/data  in   adder result
//   add_ready       out  adder queue has room (from registered count)
//   mul_valid/tag/data  in   multiplier result
//   mul_ready       out  multiplier queue has room (from registered count)
//   cdb_hold        in   consumer stalls the bus this cycle
//   cdb_valid/tag/data  out  registered one-cycle broadcast
//   err_tag0        out  sticky: a valid input carried tag 0
//   stat_add_bcast  out  (CDB_STATS_EN) adder broadcasts, saturating
//   stat_mul_bcast  out  (CDB_STATS_EN) multiplier broadcasts, saturating
//   stat_hold       out  (CDB_STATS_EN) held edges with data pending, saturating

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DATA_W = CDB_DATA_W,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DEPTH  = CDB_DEPTH
) (
  input  logic              clock1,
  input  logic              reset,
  input  logic              add_valid,
  input  logic [TAG_W-1:0]  add_tag,
  input  logic [DATA_W-1:0] add_data,
  output logic              add_ready,
  input  logic              mul_valid,
  input  logic [TAG_W-1:0]  mul_tag,
  input  logic [DATA_W-1:0] mul_data,
  output logic              mul_ready,
  input  logic              cdb_hold,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              err_tag0
`ifdef CDB_STATS_EN
  ,
  output logic [15:0]       stat_add_bcast,
  output logic [15:0]       stat_mul_bcast,
  output logic [15:0]       stat_hold
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Local entry type so that overridden widths flow into the queues.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           add_in;
  entry_t           mul_in;
  entry_t           add_head;
  entry_t           mul_head;
  logic             add_full;
  logic             mul_full;
  logic             add_empty;
  logic             mul_empty;
  logic [CNT_W-1:0] add_count;
  logic [CNT_W-1:0] mul_count;
  logic             add_tag0;
  logic             mul_tag0;
  logic             add_push;
  logic             mul_push;
  logic             grant_add;
  logic             grant_mul;
  logic             pop_add;
  logic             pop_mul;
  cdb_src_e         last_grant;

  assign add_in = '{tag: add_tag, data: add_data};
  assign mul_in = '{tag: mul_tag, data: mul_data};

  // Ready comes from the registered count only; a same-cycle pop does not help.
  assign add_ready = (add_count < CNT_W'(DEPTH));
  assign mul_ready = (mul_count < CNT_W'(DEPTH));

  // Tag 0 means "no producer": flagged, never enqueued, consumes no slot.
  assign add_tag0 = add_valid & (add_tag == TAG_W'(TAG_NONE));
  assign mul_tag0 = mul_valid & (mul_tag == TAG_W'(TAG_NONE));
  assign add_push = add_valid & ~add_full & ~add_tag0;
  assign mul_push = mul_valid & ~mul_full & ~mul_tag0;

  // Round-robin: on a tie the source that did not win last time goes first.
  assign grant_add = ~add_empty & (mul_empty | (last_grant == SRC_MUL));
  assign grant_mul = ~mul_empty & (add_empty | (last_grant == SRC_ADD));
  assign pop_add   = ~cdb_hold & grant_add;
  assign pop_mul   = ~cdb_hold & grant_mul;

  cdb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_add_q (
    .clock1     (clock1),
    .reset      (reset),
    .push       (add_push),
    .push_entry (add_in),
    .pop        (pop_add),
    .head       (add_head),
    .full       (add_full),
    .empty      (add_empty),
    .count      (add_count)
  );

  cdb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mul_q (
    .clock1     (clock1),
    .reset      (reset),
    .push       (mul_push),
    .push_entry (mul_in),
    .pop        (pop_mul),
    .head       (mul_head),
    .full       (mul_full),
    .empty      (mul_empty),
    .count      (mul_count)
  );

  always_ff @(posedge clock1) begin
    if (reset) begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
      err_tag0   <= 1'b0;
      last_grant <= SRC_MUL;
    end else begin
      if (add_tag0 | mul_tag0) begin
        err_tag0 <= 1'b1;
      end
      // While held or idle the bus keeps its last tag/data, only valid drops.
      if (pop_add) begin
        cdb_valid  <= 1'b1;
        cdb_tag    <= add_head.tag;
        cdb_data   <= add_head.data;
        last_grant <= SRC_ADD;
      end else if (pop_mul) begin
        cdb_valid  <= 1'b1;
        cdb_tag    <= mul_head.tag;
        cdb_data   <= mul_head.data;
        last_grant <= SRC_MUL;
      end else begin
        cdb_valid  <= 1'b0;
      end
    end
  end

`ifdef CDB_STATS_EN
  always_ff @(posedge clock1) begin
    if (reset) begin
      stat_add_bcast <= '0;
      stat_mul_bcast <= '0;
      stat_hold      <= '0;
    end else begin
      if (pop_add && stat_add_bcast != 16'hFFFF) begin
        stat_add_bcast <= stat_add_bcast + 16'd1;
      end
      if (pop_mul && stat_mul_bcast != 16'hFFFF) begin
        stat_mul_bcast <= stat_mul_bcast + 16'd1;
      end
      if (cdb_hold && (~add_empty || ~mul_empty) && stat_hold != 16'hFFFF) begin
        stat_hold <= stat_hold + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter

module tb_cdb_arbiter;

  logic        clock1;
  logic        reset;
  logic        add_valid;
  logic [2:0]  add_tag;
  logic [15:0] add_data;
  logic        add_ready;
  logic        mul_valid;
  logic [2:0]  mul_tag;
  logic [15:0] mul_data;
  logic        mul_ready;
  logic        cdb_hold;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        err_tag0;
`ifdef CDB_STATS_EN
  logic [15:0] stat_add_bcast;
  logic [15:0] stat_mul_bcast;
  logic [15:0] stat_hold;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter dut (
    .clock1    (clock1),
    .reset     (reset),
    .add_valid (add_valid),
    .add_tag   (add_tag),
    .add_data  (add_data),
    .add_ready (add_ready),
    .mul_valid (mul_valid),
    .mul_tag   (mul_tag),
    .mul_data  (mul_data),
    .mul_ready (mul_ready),
    .cdb_hold  (cdb_hold),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .err_tag0  (err_tag0)
`ifdef CDB_STATS_EN
    ,
    .stat_add_bcast (stat_add_bcast),
    .stat_mul_bcast (stat_mul_bcast),
    .stat_hold      (stat_hold)
`endif
  );

  initial clock1 = 1'b0;
  always #5 clock1 = ~clock1;

  // Reference model: two plain queues plus the last winner.
  typedef struct packed {
    logic [2:0]  tag;
    logic [15:0] data;
  } ent_t;

  ent_t        qa[$];
  ent_t        qm[$];
  int          m_last;
  logic        m_valid;
  logic [2:0]  m_tag;
  logic [15:0] m_data;
  logic        m_err;
  int          m_sa;
  int          m_sm;
  int          m_sh;

  function automatic void model_edge();
    int   g;
    ent_t e;
    if (reset) begin
      qa.delete();
      qm.delete();
      m_last  = 1;
      m_valid = 1'b0;
      m_tag   = '0;
      m_data  = '0;
      m_err   = 1'b0;
      m_sa = 0; m_sm = 0; m_sh = 0;
    end else begin
      g = -1;
      if (cdb_hold) begin
        if (qa.size() > 0 || qm.size() > 0) m_sh = (m_sh < 65535) ? m_sh + 1 : m_sh;
      end else if (qa.size() > 0 && qm.size() > 0) begin
        g = (m_last == 1) ? 0 : 1;
      end else if (qa.size() > 0) begin
        g = 0;
      end else if (qm.size() > 0) begin
        g = 1;
      end
      if ((add_valid && add_tag == 3'd0) || (mul_valid && mul_tag == 3'd0)) m_err = 1'b1;
      if (add_valid && add_tag != 3'd0 && qa.size() < 4) qa.push_back({add_tag, add_data});
      if (mul_valid && mul_tag != 3'd0 && qm.size() < 4) qm.push_back({mul_tag, mul_data});
      if (g == 0) begin
        e = qa.pop_front();
        m_valid = 1'b1; m_tag = e.tag; m_data = e.data; m_last = 0;
        m_sa = (m_sa < 65535) ? m_sa + 1 : m_sa;
      end else if (g == 1) begin
        e = qm.pop_front();
        m_valid = 1'b1; m_tag = e.tag; m_data = e.data; m_last = 1;
        m_sm = (m_sm < 65535) ? m_sm + 1 : m_sm;
      end else begin
        m_valid = 1'b0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs, advance the model, clock one edge, sample 1 time unit later.
  task automatic step(input logic r, input logic av, input logic [2:0] at, input logic [15:0] ad,
                      input logic mv, input logic [2:0] mt, input logic [15:0] md, input logic h);
    reset = r; add_valid = av; add_tag = at; add_data = ad;
    mul_valid = mv; mul_tag = mt; mul_data = md; cdb_hold = h;
    model_edge();
    @(posedge clock1);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic        av;
    logic [2:0]  at;
    logic [15:0] ad;
    logic        mv;
    logic [2:0]  mt;
    logic [15:0] md;
    logic        h;
    logic        ev;
    logic [2:0]  et;
    logic [15:0] ed;
    logic        ear;
    logic        eerr;
  } vec_t;

  vec_t vt[26];

  initial begin
    reset = 1'b1; add_valid = 1'b0; add_tag = '0; add_data = '0;
    mul_valid = 1'b0; mul_tag = '0; mul_data = '0; cdb_hold = 1'b0;
    m_last = 1; m_valid = 1'b0; m_tag = '0; m_data = '0; m_err = 1'b0;
    m_sa = 0; m_sm = 0; m_sh = 0;

    //          r  av at d       mv mt d       h   ev et d       rdy err
    // single result
    vt[0]  = '{1, 0, 0, 16'h0,  0, 0, 16'h0,  0,  0, 0, 16'h0,  1, 0};
    vt[1]  = '{0, 1, 1, 16'h5,  0, 0, 16'h0,  0,  0, 0, 16'h0,  1, 0};
    vt[2]  = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  1, 1, 16'h5,  1, 0};
    vt[3]  = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  0, 1, 16'h5,  1, 0};
    // contention after reset: adder wins the first tie
    vt[4]  = '{1, 0, 0, 16'h0,  0, 0, 16'h0,  0,  0, 0, 16'h0,  1, 0};
    vt[5]  = '{0, 1, 2, 16'h7,  1, 5, 16'hc,  0,  0, 0, 16'h0,  1, 0};
    vt[6]  = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  1, 2, 16'h7,  1, 0};
    vt[7]  = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  1, 5, 16'hc,  1, 0};
    vt[8]  = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  0, 5, 16'hc,  1, 0};
    // full adder queue under hold, 5th push dropped, drain in order
    vt[9]  = '{0, 1, 1, 16'h11, 0, 0, 16'h0,  1,  0, 5, 16'hc,  1, 0};
    vt[10] = '{0, 1, 2, 16'h22, 0, 0, 16'h0,  1,  0, 5, 16'hc,  1, 0};
    vt[11] = '{0, 1, 3, 16'h33, 0, 0, 16'h0,  1,  0, 5, 16'hc,  1, 0};
    vt[12] = '{0, 1, 4, 16'h44, 0, 0, 16'h0,  1,  0, 5, 16'hc,  0, 0};
    vt[13] = '{0, 1, 5, 16'h55, 0, 0, 16'h0,  1,  0, 5, 16'hc,  0, 0};
    vt[14] = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  1, 1, 16'h11, 1, 0};
    vt[15] = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  1, 2, 16'h22, 1, 0};
    vt[16] = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  1, 3, 16'h33, 1, 0};
    vt[17] = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  1, 4, 16'h44, 1, 0};
    vt[18] = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  0, 4, 16'h44, 1, 0};
    // tag 0 flagged and dropped, then reset discards queued results
    vt[19] = '{0, 0, 0, 16'h0,  1, 0, 16'h99, 0,  0, 4, 16'h44, 1, 1};
    vt[20] = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  0, 4, 16'h44, 1, 1};
    vt[21] = '{0, 1, 1, 16'h101,1, 2, 16'h202,1,  0, 4, 16'h44, 1, 1};
    vt[22] = '{0, 1, 3, 16'h303,0, 0, 16'h0,  1,  0, 4, 16'h44, 1, 1};
    vt[23] = '{1, 0, 0, 16'h0,  0, 0, 16'h0,  0,  0, 0, 16'h0,  1, 0};
    vt[24] = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  0, 0, 16'h0,  1, 0};
    vt[25] = '{0, 0, 0, 16'h0,  0, 0, 16'h0,  0,  0, 0, 16'h0,  1, 0};

    for (int i = 0; i < 26; i++) begin
      step(vt[i].r, vt[i].av, vt[i].at, vt[i].ad, vt[i].mv, vt[i].mt, vt[i].md, vt[i].h);
      check($sformatf("vec%0d cdb_valid", i), 32'(cdb_valid), 32'(vt[i].ev));
      check($sformatf("vec%0d cdb_tag", i),   32'(cdb_tag),   32'(vt[i].et));
      check($sformatf("vec%0d cdb_data", i),  32'(cdb_data),  32'(vt[i].ed));
      check($sformatf("vec%0d add_ready", i), 32'(add_ready), 32'(vt[i].ear));
      check($sformatf("vec%0d err_tag0", i),  32'(err_tag0),  32'(vt[i].eerr));
    end

    // Round-robin streaming: both sources valid every cycle.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 1, 16'(k), 1, 6, 16'(100 + k), 0);
      if (k >= 1) begin
        check($sformatf("rr%0d valid", k), 32'(cdb_valid), 32'd1);
        check($sformatf("rr%0d tag", k), 32'(cdb_tag), (k % 2 == 1) ? 32'd1 : 32'd6);
        check($sformatf("rr%0d data", k), 32'(cdb_data),
              (k % 2 == 1) ? 32'((k - 1) / 2) : 32'(100 + k / 2 - 1));
      end else begin
        check("rr0 valid", 32'(cdb_valid), 32'd0);
      end
    end

`ifdef CDB_STATS_EN
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("stat reset add", 32'(stat_add_bcast), 32'd0);
    check("stat reset hold", 32'(stat_hold), 32'd0);
    step(0, 1, 1, 16'h1, 1, 2, 16'h2, 1);
    step(0, 1, 3, 16'h3, 1, 4, 16'h4, 1);
    step(0, 1, 5, 16'h5, 0, 0, 16'h0, 1);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    check("stat_add_bcast", 32'(stat_add_bcast), 32'd3);
    check("stat_mul_bcast", 32'(stat_mul_bcast), 32'd2);
    check("stat_hold", 32'(stat_hold), 32'd2);
`endif

    // Randomized traffic against the queue model.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 79) == 0),
           ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 16'($urandom),
           ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 16'($urandom),
           ($urandom_range(0, 3) == 0));
      check("rnd cdb_valid", 32'(cdb_valid), 32'(m_valid));
      check("rnd cdb_tag",   32'(cdb_tag),   32'(m_tag));
      check("rnd cdb_data",  32'(cdb_data),  32'(m_data));
      check("rnd err_tag0",  32'(err_tag0),  32'(m_err));
      check("rnd add_ready", 32'(add_ready), 32'(qa.size() < 4));
      check("rnd mul_ready", 32'(mul_ready), 32'(qm.size() < 4));
`ifdef CDB_STATS_EN
      check("rnd stat_add", 32'(stat_add_bcast), 32'(m_sa));
      check("rnd stat_mul", 32'(stat_mul_bcast), 32'(m_sm));
      check("rnd stat_hold", 32'(stat_hold), 32'(m_sh));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common-data-bus stage directly downstream of the Tomasulo adder and multiplier reservation-station/execute units.
- Buffers completed results from each functional unit in a per-source queue.
- Arbitrates round-robin and broadcasts at most one {tag, data} per cycle on the CDB, which feeds back into the register table and the waiting reservation-station operands.

Parameters:
- DATA_W, 16, result/operand width (matches register-table entry width).
- TAG_W, 3, reservation-station tag width; tag value 0 means "no producer".
- DEPTH, 4, entries per source queue (power of two, min 2).

Ports:
- clock1 input 1: single clock; all state updates on rising edge.
- reset input 1: synchronous, active-high.
- add_valid input 1: adder result present.
- add_tag input TAG_W: producing adder-station tag.
- add_data input DATA_W: adder result.
- add_ready output 1: adder queue can accept.
- mul_valid input 1: multiplier result present.
- mul_tag input TAG_W: producing multiplier-station tag.
- mul_data input DATA_W: multiplier result.
- mul_ready output 1: multiplier queue can accept.
- cdb_hold input 1: consumer requests no broadcast this cycle.
- cdb_valid output 1: broadcast valid (registered).
- cdb_tag output TAG_W: broadcast tag (registered).
- cdb_data output DATA_W: broadcast value (registered).
- err_tag0 output 1: sticky; a valid input carried tag 0.

Behaviour:
- Reset (sampled at rising clock1 with reset=1): both queues empty; cdb_valid=0, cdb_tag=0, cdb_data=0; err_tag0=0; last_grant=MUL, so ADD wins the first tie. reset mid-operation discards all queued results.
- Push: src_valid & src_ready at an edge enqueues {tag, data}. src_ready = (count < DEPTH), derived from registered count only. A pop in the same cycle does not raise ready.
- Tag 0: a valid input with tag==0 is never enqueued and consumes no slot; err_tag0 sets and holds until reset.
- Arbitration, evaluated each edge when cdb_hold=0:
  - Only one queue non-empty: pop its head.
  - Both non-empty: pop the source that is not last_grant, then update last_grant.
  - Neither non-empty: cdb_valid<=0.
- Broadcast: the popped entry drives cdb_tag/cdb_data and sets cdb_valid<=1 on the same edge, so each broadcast lasts exactly one cycle.
- Latency: an input accepted at edge N into an empty queue, with no contention and no hold, appears with cdb_valid=1 after edge N+1.
- cdb_hold=1 at an edge: no pop; cdb_valid<=0; cdb_tag/cdb_data keep their last values; last_grant unchanged.
- Queues: circular buffers with read/write pointers wrapping modulo DEPTH. Count width is clog2(DEPTH)+1.
- Simultaneous push and pop on the same queue: count unchanged, order preserved.
- Ordering: FIFO within each source. There is no ordering guarantee across sources.
- No data transformation: width is preserved, with no arithmetic on data.

Optional Feature:
- Macro CDB_STATS_EN.
- When defined, adds outputs stat_add_bcast (16), stat_mul_bcast (16) and stat_hold (16).
  - stat_add_bcast / stat_mul_bcast count broadcasts per source.
  - stat_hold counts edges with cdb_hold=1 while at least one queue is non-empty.
  - All three are saturating at 16'hFFFF and reset to 0.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package cdb_pkg holds:
  - DATA_W/TAG_W defaults;
  - TAG_NONE = 0;
  - source enum {SRC_ADD = 0, SRC_MUL = 1};
  - typedef cdb_entry_t = {tag, data}.
- Sub-module cdb_fifo (parameters DEPTH, entry type) provides push/pop/full/empty/count and is instantiated once per source.
- Arbitration, hold handling, error flag and stats stay in cdb_arbiter.

Test Plan:
- Single result: reset, then add_valid=1, tag=1, data=16'h0005 for one cycle → cdb_valid=1, tag=1, data=5 exactly one cycle later, for one cycle; add_ready stays 1.
- Contention: add (tag 2, data 7) and mul (tag 5, data 12) on the same edge after reset → broadcasts tag 2/7, then tag 5/12 on consecutive cycles.
- Round-robin streaming: hold both valid continuously with incrementing data → grants alternate A, M, A, M; neither source is starved.
- Full queue: cdb_hold=1, push 4 adder results (tags 1-4) → add_ready=0 after the 4th; a 5th push is ignored. Release hold → tags 1, 2, 3, 4 broadcast in order on 4 consecutive cycles; add_ready returns to 1 after the first pop.
- Tag 0 and reset: push mul tag 0 → err_tag0=1, nothing broadcast. Then queue 3 entries and assert reset for one edge → queues empty, cdb_valid=0, err_tag0=0, no stale broadcast afterwards.
- Stats (CDB_STATS_EN): 3 add broadcasts, 2 mul broadcasts, 2 held cycles with data pending → stat_add_bcast=3, stat_mul_bcast=2, stat_hold=2.
